pipe_reg_buf: RTL and testbench

PIPE_REG_BUF -- requirements
Module: pipe_reg_buf

---
 rtl/pipe_reg_buf.sv | 172 +++++++++++++++++
 tb/tb_pipe_reg_buf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_buf
// Brief    : Small valid/ready pipeline buffer (circular FIFO of DEPTH
//            entries) with flush, occupancy state tracking and an optional
//            backpressure stall counter.
//            Optional feature macro: PIPE_STALL_CNT_EN (compiles in the
//            saturating 16-bit stall counter; otherwise stall_cnt is 0).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                stall_cnt
);

    // Pointer width is at least one bit so a single-entry buffer still has
    // a legal (constant-zero) pointer.
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    // Occupancy state; PARTIAL is never entered when DEPTH is 1.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

    occ_state_t          r_state;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_out_valid;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_enq;
    logic                w_deq;
    logic [c_ptr_w-1:0]  w_wr_ptr_nxt;
    logic [c_ptr_w-1:0]  w_rd_ptr_nxt;

    // Ready depends only on registered occupancy: a full buffer never
    // accepts data even if the head is being consumed in the same cycle.
    assign in_ready  = (r_count < c_depth);
    assign out_valid = r_out_valid;
    assign count     = r_count;

    // Zero the payload whenever nothing valid is held, so stale storage
    // never leaks onto the output bus.
    assign out_data  = r_out_valid ? r_mem[r_rd_ptr] : '0;

    assign w_enq = in_valid & in_ready;
    assign w_deq = r_out_valid & out_ready;

    // Explicit wrap keeps DEPTH=1 pinned at zero and never skips an entry.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : (r_wr_ptr + c_ptr_one);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : (r_rd_ptr + c_ptr_one);

    // Payload storage: cleared on reset, written on each accepted enqueue.
    // Flush leaves the contents alone; they are unreachable once count is 0.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush && w_enq) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer advance; reset and flush both return to entry 0.
    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_deq) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
        end
    end

    // Occupancy FSM with registered count and out_valid.
    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            r_state     <= EMPTY;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    // A dequeue request here is ignored: nothing is valid.
                    if (w_enq) begin
                        r_count     <= c_cnt_one;
                        r_out_valid <= 1'b1;
                        r_state     <= (DEPTH == 1) ? FULL : PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (w_enq && !w_deq) begin
                        r_count <= r_count + c_cnt_one;
                        if ((r_count + c_cnt_one) == c_depth) begin
                            r_state <= FULL;
                        end
                    end else if (!w_enq && w_deq) begin
                        r_count <= r_count - c_cnt_one;
                        if (r_count == c_cnt_one) begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                    // Simultaneous enqueue and dequeue keeps count steady.
                end
                FULL: begin
                    // in_ready is low here, so only a dequeue can happen.
                    if (w_deq) begin
                        r_count <= r_count - c_cnt_one;
                        if (DEPTH == 1) begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state <= PARTIAL;
                        end
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_count     <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count cycles where valid data is held back by downstream; saturates
    // and survives flush so long-running backpressure stays visible.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt <= 16'h0000;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_reg_buf
// Brief    : Directed self-checking bench for pipe_reg_buf. Exercises the
//            default DEPTH=2 build plus DEPTH=1 and DEPTH=8 instances.
//            Optional feature macro: PIPE_STALL_CNT_EN (long stall test).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_buf;

    logic        CLK;
    logic        nRST;

    // DEPTH=2 instance
    logic        m_flush, m_in_valid, m_out_ready;
    logic [31:0] m_in_data;
    wire         m_in_ready, m_out_valid;
    wire  [31:0] m_out_data;
    wire  [1:0]  m_count;
    wire  [15:0] m_stall;

    // DEPTH=1 instance
    logic        a_flush, a_in_valid, a_out_ready;
    logic [31:0] a_in_data;
    wire         a_in_ready, a_out_valid;
    wire  [31:0] a_out_data;
    wire  [0:0]  a_count;
    wire  [15:0] a_stall;

    // DEPTH=8 instance
    logic        b_flush, b_in_valid, b_out_ready;
    logic [31:0] b_in_data;
    wire         b_in_ready, b_out_valid;
    wire  [31:0] b_out_data;
    wire  [3:0]  b_count;
    wire  [15:0] b_stall;

    int n_vec = 0;
    int n_err = 0;

    pipe_reg_buf #(.DATA_W(32), .DEPTH(2)) u_dut (
        .CLK(CLK), .nRST(nRST), .flush(m_flush),
        .in_valid(m_in_valid), .in_data(m_in_data), .in_ready(m_in_ready),
        .out_valid(m_out_valid), .out_data(m_out_data), .out_ready(m_out_ready),
        .count(m_count), .stall_cnt(m_stall)
    );

    pipe_reg_buf #(.DATA_W(32), .DEPTH(1)) u_dut_d1 (
        .CLK(CLK), .nRST(nRST), .flush(a_flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .count(a_count), .stall_cnt(a_stall)
    );

    pipe_reg_buf #(.DATA_W(32), .DEPTH(8)) u_dut_d8 (
        .CLK(CLK), .nRST(nRST), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .count(b_count), .stall_cnt(b_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        m_flush = 0; m_in_valid = 0; m_out_ready = 0; m_in_data = '0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 32'(m_out_valid), 32'd0);
        chk("rst_data",  m_out_data,       32'h0);
        chk("rst_ready", 32'(m_in_ready),  32'd1);
        chk("rst_count", 32'(m_count),     32'd0);
        chk("rst_stall", 32'(m_stall),     32'd0);
        nRST = 1'b1;
        tick();

        // Single enqueue into EMPTY
        m_in_valid = 1; m_in_data = 32'hA5A5_0001;
        tick();
        m_in_valid = 0;
        chk("lat_valid", 32'(m_out_valid), 32'd1);
        chk("lat_data",  m_out_data,       32'hA5A5_0001);
        chk("lat_count", 32'(m_count),     32'd1);
        chk("lat_ready", 32'(m_in_ready),  32'd1);
        m_out_ready = 1;
        tick();
        m_out_ready = 0;
        chk("lat_drain", 32'(m_count), 32'd0);

        // Fill past FULL, then drain
        m_in_valid = 1; m_in_data = 32'h11; tick();
        m_in_data = 32'h22; tick();
        chk("full_count", 32'(m_count),    32'd2);
        chk("full_ready", 32'(m_in_ready), 32'd0);
        m_in_data = 32'h33; tick();
        m_in_valid = 0;
        chk("full_hold_count", 32'(m_count), 32'd2);
        chk("full_head",       m_out_data,   32'h11);
        m_out_ready = 1;
        tick();
        chk("drain1_data",  m_out_data,   32'h22);
        chk("drain1_count", 32'(m_count), 32'd1);
        tick();
        chk("drain2_valid", 32'(m_out_valid), 32'd0);
        chk("drain2_data",  m_out_data,       32'h0);
        tick();
        chk("empty_rd_count", 32'(m_count),     32'd0);
        chk("empty_rd_valid", 32'(m_out_valid), 32'd0);
        m_out_ready = 0;

        // Streaming: one in, one out per cycle
        m_in_valid = 1; m_in_data = 32'h1; tick();
        chk("stream_fill", 32'(m_count), 32'd1);
        m_out_ready = 1;
        for (int k = 2; k <= 16; k++) begin
            m_in_data = 32'(k);
            tick();
            chk("stream_data",  m_out_data,   32'(k));
            chk("stream_count", 32'(m_count), 32'd1);
        end
        m_in_valid = 0;
        tick();
        chk("stream_end", 32'(m_out_valid), 32'd0);
        m_out_ready = 0;

        // Flush overrides same-cycle enqueue and dequeue
        m_in_valid = 1; m_in_data = 32'hDEAD; tick();
        m_in_data = 32'hBEEF; tick();
        chk("pflush_count", 32'(m_count), 32'd2);
        m_flush = 1; m_in_data = 32'h1234; m_out_ready = 1;
        tick();
        m_flush = 0; m_in_valid = 0; m_out_ready = 0;
        chk("flush_count", 32'(m_count),     32'd0);
        chk("flush_valid", 32'(m_out_valid), 32'd0);
        chk("flush_ready", 32'(m_in_ready),  32'd1);
        chk("flush_data",  m_out_data,       32'h0);
        tick();
        chk("flush_nodata", 32'(m_count), 32'd0);

        // Ordering after flush: pointers restarted cleanly
        m_in_valid = 1; m_in_data = 32'hC0DE; tick();
        m_in_valid = 0;
        chk("pf_data", m_out_data, 32'hC0DE);

        // Reset mid-burst with handshakes pending
        m_in_valid = 1; m_in_data = 32'h77; m_out_ready = 1; nRST = 0;
        tick();
        nRST = 1; m_in_valid = 0; m_out_ready = 0;
        chk("mrst_count", 32'(m_count),     32'd0);
        chk("mrst_valid", 32'(m_out_valid), 32'd0);
        chk("mrst_ready", 32'(m_in_ready),  32'd1);
        chk("mrst_data",  m_out_data,       32'h0);

        // Backpressure counter
        m_in_valid = 1; m_in_data = 32'h5; tick();
        m_in_valid = 0;
`ifdef PIPE_STALL_CNT_EN
        repeat (70000) tick();
        chk("stall_sat", 32'(m_stall), 32'h0000_FFFF);
        m_flush = 1; tick(); m_flush = 0;
        chk("stall_flush", 32'(m_stall), 32'h0000_FFFF);
        nRST = 0; tick(); nRST = 1;
        chk("stall_rst", 32'(m_stall), 32'h0);
`else
        repeat (5) tick();
        chk("stall_off", 32'(m_stall), 32'h0);
        m_flush = 1; tick(); m_flush = 0;
`endif

        // DEPTH=1
        a_in_valid = 1; a_in_data = 32'hA1; tick();
        chk("d1_count", 32'(a_count),    32'd1);
        chk("d1_ready", 32'(a_in_ready), 32'd0);
        a_in_data = 32'hA2; tick();
        chk("d1_hold", a_out_data, 32'hA1);
        a_in_valid = 0; a_out_ready = 1; tick();
        chk("d1_empty", 32'(a_out_valid), 32'd0);
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'hA3; tick();
        a_in_valid = 0;
        chk("d1_next", a_out_data, 32'hA3);

        // DEPTH=8
        b_in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            b_in_data = 32'h80 + 32'(i);
            tick();
            chk("d8_fill", 32'(b_count), 32'(i + 1));
        end
        chk("d8_ready", 32'(b_in_ready), 32'd0);
        b_in_data = 32'hFF; tick();
        b_in_valid = 0;
        chk("d8_cap", 32'(b_count), 32'd8);
        b_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("d8_order", b_out_data, 32'h80 + 32'(i));
            tick();
        end
        b_out_ready = 0;
        chk("d8_empty", 32'(b_out_valid), 32'd0);
        b_in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            b_in_data = 32'h90 + 32'(i);
            tick();
        end
        // Shared reset lands mid-burst on both small instances
        a_in_valid = 1; a_in_data = 32'hAA;
        b_out_ready = 1; nRST = 0;
        tick();
        nRST = 1; a_in_valid = 0; b_in_valid = 0; b_out_ready = 0;
        chk("d8_rst_count", 32'(b_count),     32'd0);
        chk("d8_rst_valid", 32'(b_out_valid), 32'd0);
        chk("d8_rst_ready", 32'(b_in_ready),  32'd1);
        chk("d8_rst_data",  b_out_data,       32'h0);
        chk("d1_rst_count", 32'(a_count),     32'd0);
        chk("d1_rst_ready", 32'(a_in_ready),  32'd1);
        chk("d1_rst_data",  a_out_data,       32'h0);
        b_in_valid = 1; b_in_data = 32'hB0; tick();
        b_in_data = 32'hB1; tick();
        b_in_valid = 0; b_out_ready = 1;
        chk("d8_post0", b_out_data, 32'hB0);
        tick();
        chk("d8_post1", b_out_data, 32'hB1);
        b_out_ready = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
